rv_divider: RTL and testbench
=============================

# rv_divider

- Multi-cycle restoring integer divider for the RV32M divide group (DIV, DIVU, REM, REMU).
- Performs the inverse of the datapath's adder chain: one trial subtraction per cycle, one quotient bit per cycle.
- Sits beside the ALU in the execute stage; the hazard unit stalls the pipeline while `busy` is high and resumes on `done`.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥ 2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when `busy` = 0
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  WIDTH  rs1 value; sampled on accept only
- divisor  in  WIDTH  rs2 value; sampled on accept only
- flush  in  1  abort the in-flight operation (branch mispredict / trap)
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; `result` valid this cycle
- result  out  WIDTH  quotient or remainder per `op`; held until the next `done`

## Operation
States:
- IDLE: waiting for `start`.
- CALC: iterating.
- DONE: presenting the result.

Transitions:
- IDLE or DONE with `start` = 1 and `flush` = 0 → CALC. On accept, latch `op`, the operand magnitudes (absolute values for signed ops, raw values for unsigned), the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign). Load the iteration counter with WIDTH−1 and clear the partial remainder.
- CALC, each cycle:
  - Shift {partial remainder, dividend-shift MSB} left by one.
  - If the shifted value ≥ divisor magnitude: subtract, and shift quotient bit 1 in; otherwise shift 0 in.
  - Decrement the counter; when the counter is 0 at the clock edge, go to DONE.
- DONE → IDLE after one cycle, unless a new `start` is accepted in that cycle.

Result fixup (applied when entering DONE):
- DIV/DIVU: quotient, negated if op is signed and the quotient sign is 1.
- REM/REMU: remainder, negated if op is signed and the remainder sign is 1.

Special cases, RISC-V defined; never trap:
- divisor = 0: DIV/DIVU return all ones; REM/REMU return the dividend unchanged.
- Signed overflow (dividend = −2^(WIDTH−1), divisor = −1): DIV returns −2^(WIDTH−1); REM returns 0.

Arithmetic:
- Partial remainder is WIDTH+1 bits so the compare never overflows.
- The most negative dividend's magnitude (2^(WIDTH−1)) is held correctly as unsigned.

## Timing
- Reset: state IDLE, `busy` = 0, `done` = 0, `result` = 0, all internal registers 0.
- Latency: `start` accepted at edge t → `done` high in the cycle after edge t+WIDTH. That is WIDTH+1 cycles; 33 at WIDTH = 32.
- `busy` is 1 in CALC only; 0 in IDLE and DONE. This allows back-to-back operations: `start` during DONE is accepted.
- `start` while `busy` = 1 is ignored; the operation is not queued.
- `flush` at any state → IDLE at the next edge; `done` is not asserted and `result` keeps its previous value.
- `flush` and `start` in the same cycle: flush wins and start is dropped.
- `rst` mid-operation behaves like flush, but also clears `result`.
- Operand inputs may change freely after the accept cycle.

## Configuration
- `RV_DIV_FAST_SPECIAL_EN` defined:
  - Divide-by-zero and signed overflow are detected in the accept cycle, which goes directly to DONE.
  - `done` arrives one cycle after accept.
  - `busy` stays 0 throughout.
- Not defined:
  - Special cases run the full WIDTH iterations and get forced results at DONE.
  - Latency is WIDTH+1 for every operation.
- Result values are identical in both builds; only latency differs.

## Test plan
- Reset: assert `rst` 2 cycles → `busy` = 0, `done` = 0, `result` = 0.
- DIVU 100 / 7, then REMU 100 / 7 → 14 and 2; each `done` exactly 33 cycles after its accept; `busy` high for 32 cycles.
- Signed ops on −7, 2:
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - DIV 7 / −2 → −3.
  - REM 7 / −2 → 1.
- Special cases:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000.
  - REM 0x80000000 / −1 → 0.
  - Latency is 1 with `RV_DIV_FAST_SPECIAL_EN`, 33 without.
- Flush and dropped start:
  - Start DIVU 1000 / 3, pulse `flush` at cycle 10 → no `done`, `busy` = 0 the next cycle, `result` unchanged.
  - `start` with `flush` in the same cycle → not accepted.
- Back-to-back: `start` held during the DONE cycle with DIVU 0xFFFFFFFF / 1 → second op accepted immediately, `done` 33 cycles later with 0xFFFFFFFF; a `start` pulsed mid-CALC is ignored.

Source files
------------

// File: rtl/rv_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro RV_DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module rv_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             signed_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero;
    logic [WIDTH:0]   shifted, diff, rem_next;
    logic             ge;
    logic [WIDTH-1:0] quo_next, rem_low, quo_fix, rem_fix;
    logic             signed_q;
`ifdef RV_DIV_FAST_SPECIAL_EN
    logic             ovf;
`endif

    always_comb begin
        signed_in = ~op[0];
        a_neg     = signed_in & dividend[WIDTH-1];
        b_neg     = signed_in & divisor[WIDTH-1];
        a_mag     = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag     = b_neg ? (~divisor + 1'b1) : divisor;
        div_zero  = (divisor == '0);
`ifdef RV_DIV_FAST_SPECIAL_EN
        ovf       = signed_in && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif

        // Dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
        shifted  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? diff : shifted;
        quo_next = {dvd_q[WIDTH-2:0], ge};
        rem_low  = rem_next[WIDTH-1:0];

        signed_q = ~op_q[0];
        quo_fix  = (signed_q && qneg_q) ? (~quo_next + 1'b1) : quo_next;
        rem_fix  = (signed_q && rneg_q) ? (~rem_low + 1'b1) : rem_low;
        if (div0_q) quo_fix = '1;

        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    state_d = S_CALC;
                    op_d    = op;
                    rem_d   = '0;
                    dvd_d   = a_mag;
                    dvs_d   = b_mag;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    div0_d  = div_zero;
                    cnt_d   = CW'(WIDTH - 1);
`ifdef RV_DIV_FAST_SPECIAL_EN
                    if (div_zero || ovf) begin
                        state_d  = S_DONE;
                        result_d = op[1] ? (div_zero ? dividend : '0)
                                         : (div_zero ? '1 : dividend);
                    end
`endif
                end
            end
            S_CALC: begin
                rem_d = rem_next;
                dvd_d = quo_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = op_q[1] ? rem_fix : quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == S_CALC);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_rv_divider.sv
// Self-checking bench for rv_divider: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_rv_divider;

    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]  divisor;
    logic              flush;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] last_result = '0;

    rv_divider #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics written directly from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : MIN_NEG;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (DUT still in DONE).
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit glitch);
        logic [31:0] exp;
        int unsigned lat_exp, n, busy_cnt;
        bit seen;
        exp = ref_div(o, a, b);
        lat_exp = WIDTH + 1;
`ifdef RV_DIV_FAST_SPECIAL_EN
        if (is_special(o, a, b)) lat_exp = 1;
`endif
        start = 1'b1; op = o; dividend = a; divisor = b;
        tick();
        start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        n = 1; busy_cnt = 0; seen = 0;
        while (n <= 100) begin
            if (glitch && n == 10) begin
                start = 1'b1; op = 2'd1; dividend = 32'd9; divisor = 32'd3;
            end
            if (glitch && n == 11) start = 1'b0;
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(seen), 32'd1);
        check({tag, " latency"}, n, lat_exp);
        check({tag, " busy_cycles"}, busy_cnt, lat_exp - 1);
        check({tag, " result"}, result, exp);
        last_result = exp;
    endtask

    task automatic idle_check(input string tag);
        tick();
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " held"}, result, last_result);
    endtask

    task automatic watch_no_done(input string tag, input int unsigned cycles);
        int unsigned hits = 0;
        repeat (cycles) begin
            tick();
            if (done) hits++;
        end
        check({tag, " no_done"}, hits, 32'd0);
        check({tag, " result_held"}, result, last_result);
    endtask

    initial begin
        logic [1:0] o;
        logic [31:0] a, b;
        int unsigned n;

        rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        tick();

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
        idle_check("divu_100_7");
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
        idle_check("remu_100_7");

        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        idle_check("signed");

        run_op("div_5_0", 2'b00, 32'd5, 32'd0, 0);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 0);
        run_op("div_ovf", 2'b00, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 2'b10, MIN_NEG, 32'hFFFF_FFFF, 0);
        run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0);
        idle_check("special");

        // Flush mid-calculation: result must survive, no done afterwards.
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            tick();
            n++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result", result, last_result);
        watch_no_done("flush", 40);

        // Start together with flush is dropped.
        start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        check("start_flush busy", 32'(busy), 32'd0);
        watch_no_done("start_flush", 40);

        // Back-to-back: second start issued in the DONE cycle, plus a stray start mid-CALC.
        run_op("b2b_first", 2'b01, 32'd1000, 32'd3, 0);
        run_op("b2b_second", 2'b01, 32'hFFFF_FFFF, 32'd1, 1);
        idle_check("b2b");

        // Reset mid-operation clears the result.
        start = 1'b1; op = 2'b01; dividend = 32'd77; divisor = 32'd5;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        last_result = '0;
        tick();

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 20);
                3: b = 32'd0 - $urandom_range(1, 20);
                4: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), o, a, b,
                   (!is_special(o, a, b)) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
